// File: rtl/lutram_fifo.sv
// First-word-fall-through FIFO on distributed RAM with valid/ready on both sides.
// Define LUTRAM_FIFO_LEVEL_EN to build the occupancy and almost-full outputs.
module lutram_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5,
  parameter int AF_LEVEL   = 2**ADDR_BITS - 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [ADDR_BITS:0]    level_o,
  output logic                  almost_full_o
);

  localparam int DEPTH = 2**ADDR_BITS;
  localparam int PW    = ADDR_BITS + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          push, pop;

  assign push = wvalid_i && !full_q;
  assign pop  = rready_i && !empty_q;

  // Next pointers and the status flags they imply; flags are registered so
  // the handshake outputs never see wvalid_i/rready_i combinationally.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end
    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[ADDR_BITS-1:0] == rptr_d[ADDR_BITS-1:0]) &&
              (wptr_d[ADDR_BITS] != rptr_d[ADDR_BITS]);
  end

  // Pointer and flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= {PW{1'b0}};
      rptr_q  <= {PW{1'b0}};
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage write port; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q[ADDR_BITS-1:0]] <= wdata_i;
    end
  end

  assign rdata_o  = mem_q[rptr_q[ADDR_BITS-1:0]];
  assign wready_o = !full_q;
  assign rvalid_o = !empty_q;

`ifdef LUTRAM_FIFO_LEVEL_EN
  localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);

  logic [PW-1:0] level_q, level_d;
  logic          almost_full_q, almost_full_d;

  // Occupancy derived from the next pointers so it lines up with the flags.
  always_comb begin
    level_d       = wptr_d - rptr_d;
    almost_full_d = (level_d >= AF_THR);
  end

  // Occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q       <= {PW{1'b0}};
      almost_full_q <= 1'b0;
    end else begin
      level_q       <= level_d;
      almost_full_q <= almost_full_d;
    end
  end

  assign level_o       = level_q;
  assign almost_full_o = almost_full_q;
`else
  assign level_o       = {PW{1'b0}};
  assign almost_full_o = 1'b0;
`endif

endmodule

// File: tb/tb_lutram_fifo.sv
// Randomised scoreboard bench for lutram_fifo against a queue-based reference model.
module tb_lutram_fifo;
  localparam int DW    = 8;
  localparam int AB    = 5;
  localparam int DEPTH = 32;
  localparam int AF    = 28;

  logic          clk;
  logic          rst_ni;
  logic [DW-1:0] wdata_i;
  logic          wvalid_i;
  logic          wready_o;
  logic [DW-1:0] rdata_o;
  logic          rvalid_o;
  logic          rready_i;
  logic [AB:0]   level_o;
  logic          almost_full_o;

  lutram_fifo #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .AF_LEVEL(AF)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .wdata_i(wdata_i), .wvalid_i(wvalid_i),
    .wready_o(wready_o), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
    .rready_i(rready_i), .level_o(level_o), .almost_full_o(almost_full_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_level();
`ifdef LUTRAM_FIFO_LEVEL_EN
    return exp_q.size();
`else
    return 0;
`endif
  endfunction

  function automatic logic exp_af();
`ifdef LUTRAM_FIFO_LEVEL_EN
    return exp_q.size() >= AF;
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: status vs. model each cycle, head word on every handshake.
  always @(negedge clk) begin : monitor
    int sz;
    if (rst_ni) begin
      sz = exp_q.size();
      check("wready", wready_o, sz < DEPTH);
      check("rvalid", rvalid_o, sz > 0);
      check("level", level_o, exp_level());
      check("almost_full", almost_full_o, exp_af());
      if (rready_i && sz > 0) begin
        check("rdata", rdata_o, exp_q[0]);
        void'(exp_q.pop_front());
        n_pops++;
      end
      if (wvalid_i && sz < DEPTH) exp_q.push_back(wdata_i);
    end
  end

  task automatic step(input logic wv, input logic [DW-1:0] wd, input logic rr);
    wvalid_i = wv;
    wdata_i  = wd;
    rready_i = rr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sent;
    int budget;
    int pops0;
    logic wv;
    logic rr;
    rst_ni = 1'b0;
    wvalid_i = 1'b0;
    rready_i = 1'b0;
    wdata_i = '0;
    #12 rst_ni = 1'b1;
    check("reset_wready", wready_o, 1'b1);
    check("reset_rvalid", rvalid_o, 1'b0);
    check("reset_level", level_o, 0);
    check("reset_af", almost_full_o, 1'b0);
    @(posedge clk);
    #1;

    // Fill to full, then offer an extra word that must be rejected.
    for (int i = 0; i < 32; i++) step(1'b1, DW'(i), 1'b0);
    check("full_wready", wready_o, 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    for (int i = 0; i < 33; i++) step(1'b0, 8'h00, 1'b1);
    check("drained_rvalid", rvalid_o, 1'b0);

    // Concurrent push/pop at level 5.
    for (int i = 0; i < 5; i++) step(1'b1, 8'h40 + DW'(i), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 8'h50 + DW'(i), 1'b1);
    check("pushpop_level", level_o, exp_level());
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1);

    // Full with simultaneous push and pop: only the pop proceeds.
    for (int i = 0; i < 32; i++) step(1'b1, 8'h80 + DW'(i), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    check("fullpop_wready", wready_o, 1'b1);
    check("fullpop_depth", exp_q.size(), 31);
    for (int i = 0; i < 32; i++) step(1'b0, 8'h00, 1'b1);

    // Almost-full threshold.
    for (int i = 0; i < 27; i++) step(1'b1, 8'h20 + DW'(i), 1'b0);
    check("af_at_27", almost_full_o, 1'b0);
    step(1'b1, 8'h3B, 1'b0);
`ifdef LUTRAM_FIFO_LEVEL_EN
    check("af_at_28", almost_full_o, 1'b1);
`else
    check("af_at_28", almost_full_o, 1'b0);
`endif
    for (int i = 0; i < 29; i++) step(1'b0, 8'h00, 1'b1);

    // Asynchronous reset with 12 words queued.
    for (int i = 0; i < 12; i++) step(1'b1, 8'hC0 + DW'(i), 1'b0);
    wvalid_i = 1'b0;
    rready_i = 1'b0;
    #1 rst_ni = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_rvalid", rvalid_o, 1'b0);
    check("rst_mid_wready", wready_o, 1'b1);
    check("rst_mid_level", level_o, 0);
    #1 rst_ni = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 8'h5A, 1'b0);
    check("post_rst_rvalid", rvalid_o, 1'b1);
    check("post_rst_rdata", rdata_o, 8'h5A);
    step(1'b0, 8'h00, 1'b1);
    check("post_rst_empty", rvalid_o, 1'b0);

    // Streaming with random stalls across pointer wrap.
    sent = 0;
    budget = 0;
    pops0 = n_pops;
    while ((sent < 100 || exp_q.size() > 0) && budget < 3000) begin
      wv = (sent < 100) && ($urandom_range(3) != 0);
      rr = ($urandom_range(2) != 0);
      wvalid_i = wv;
      wdata_i  = DW'(sent);
      rready_i = rr;
      if (wv && wready_o) sent++;
      @(posedge clk);
      #1;
      budget++;
    end
    check("stream_sent", sent, 100);
    check("stream_popped", n_pops - pops0, 100);
    check("stream_empty", exp_q.size(), 0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
